// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control strobes between sequencer and accumulator datapath
interface control_sequencer_if;
  logic [3:0] ir_opcode;
  logic       acc_zero;
  logic       pc_write;
  logic       pc_sel;
  logic       mar_write;
  logic       mar_sel;
  logic       mbr_write;
  logic       mbr_sel;
  logic       ir_write;
  logic       acc_write;
  logic [1:0] acc_sel;
  logic [3:0] alu_opcode;
  logic       mem_write_enable;
  logic       halted;
  logic       illegal;

  modport master (
    input  ir_opcode, acc_zero,
    output pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write,
           acc_write, acc_sel, alu_opcode, mem_write_enable, halted, illegal
  );

  modport slave (
    output ir_opcode, acc_zero,
    input  pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write,
           acc_write, acc_sel, alu_opcode, mem_write_enable, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute FSM for the 16-bit accumulator machine
// CTRL_SINGLE_STEP_EN adds a step input that releases one instruction per rising edge.
module control_sequencer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, F_ADDR, F_WAIT, F_LOAD, F_IR, DECODE,
    O_WAIT, O_LOAD, EXEC, S_MBR, S_WR, HALT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_SKIPZ = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       halted_q;
  logic       illegal_q;
  logic       start;
  logic       continue_run;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q;
  logic step_pend;

  // Every boundary parks in IDLE; a latched step edge releases exactly one instruction.
  assign start        = run && step_pend;
  assign continue_run = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q    <= step;
      step_pend <= (step_pend && !(state == IDLE && start)) || (step && !step_q);
    end
  end
`else
  assign start        = run;
  assign continue_run = run;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (start) state <= F_ADDR;
        F_ADDR: begin
          state    <= F_WAIT;
          wait_cnt <= WAIT_INIT;
        end
        F_WAIT: begin
          if (wait_cnt == 3'd0) state <= F_LOAD;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        F_LOAD: state <= F_IR;
        F_IR:   state <= DECODE;
        DECODE: begin
          case (bus.ir_opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              state    <= O_WAIT;
              wait_cnt <= WAIT_INIT;
            end
            OP_STORE: state <= S_MBR;
            OP_JUMP, OP_SKIPZ, OP_CLEAR, OP_NOP:
              state <= continue_run ? F_ADDR : IDLE;
            OP_HALT: begin
              halted_q <= 1'b1;
              state    <= HALT;
            end
            default: begin
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
              state     <= HALT;
            end
          endcase
        end
        O_WAIT: begin
          if (wait_cnt == 3'd0) state <= O_LOAD;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        O_LOAD: state <= EXEC;
        EXEC:   state <= continue_run ? F_ADDR : IDLE;
        S_MBR:  state <= S_WR;
        S_WR:   state <= continue_run ? F_ADDR : IDLE;
        HALT:   state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;

  // Strobes decode straight from state so a reset drops a pending write in the same cycle.
  always_comb begin
    bus.pc_write         = 1'b0;
    bus.pc_sel           = 1'b0;
    bus.mar_write        = 1'b0;
    bus.mar_sel          = 1'b0;
    bus.mbr_write        = 1'b0;
    bus.mbr_sel          = 1'b0;
    bus.ir_write         = 1'b0;
    bus.acc_write        = 1'b0;
    bus.acc_sel          = 2'd0;
    bus.alu_opcode       = 4'b0000;
    bus.mem_write_enable = 1'b0;
    case (state)
      F_ADDR: bus.mar_write = 1'b1;
      F_LOAD: begin
        bus.mbr_write = 1'b1;
        bus.pc_write  = 1'b1;
      end
      F_IR:   bus.ir_write = 1'b1;
      DECODE: begin
        case (bus.ir_opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            bus.mar_write = 1'b1;
            bus.mar_sel   = 1'b1;
          end
          OP_JUMP: begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = 1'b1;
          end
          OP_SKIPZ: bus.pc_write = bus.acc_zero;
          OP_CLEAR: begin
            bus.acc_write = 1'b1;
            bus.acc_sel   = 2'd2;
          end
          default: ;
        endcase
      end
      O_LOAD: bus.mbr_write = 1'b1;
      EXEC: begin
        bus.acc_write = 1'b1;
        case (bus.ir_opcode)
          OP_LOAD: bus.acc_sel    = 2'd1;
          OP_SUB:  bus.alu_opcode = 4'b0001;
          OP_AND:  bus.alu_opcode = 4'b1000;
          OP_OR:   bus.alu_opcode = 4'b1001;
          default: bus.alu_opcode = 4'b0000;
        endcase
      end
      S_MBR: begin
        bus.mbr_write = 1'b1;
        bus.mbr_sel   = 1'b1;
      end
      S_WR:   bus.mem_write_enable = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer with a small datapath model
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  always #5 clk = ~clk;

  control_sequencer_if bus();

  control_sequencer #(.MEM_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
`ifdef CTRL_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  // Output vector: {pcw pcs, marw mars, mbrw mbrs, irw, accw, acc_sel, alu, mwe hlt ill}
  localparam logic [16:0] V_FADDR  = 17'b00_10_00_0_0_00_0000_000;
  localparam logic [16:0] V_FLOAD  = 17'b10_00_10_0_0_00_0000_000;
  localparam logic [16:0] V_FIR    = 17'b00_00_00_1_0_00_0000_000;
  localparam logic [16:0] V_DMEM   = 17'b00_11_00_0_0_00_0000_000;
  localparam logic [16:0] V_DJUMP  = 17'b11_00_00_0_0_00_0000_000;
  localparam logic [16:0] V_DSKIP  = 17'b10_00_00_0_0_00_0000_000;
  localparam logic [16:0] V_DCLEAR = 17'b00_00_00_0_1_10_0000_000;
  localparam logic [16:0] V_OLOAD  = 17'b00_00_10_0_0_00_0000_000;
  localparam logic [16:0] V_EXLOAD = 17'b00_00_00_0_1_01_0000_000;
  localparam logic [16:0] V_EXADD  = 17'b00_00_00_0_1_00_0000_000;
  localparam logic [16:0] V_EXSUB  = 17'b00_00_00_0_1_00_0001_000;
  localparam logic [16:0] V_EXAND  = 17'b00_00_00_0_1_00_1000_000;
  localparam logic [16:0] V_EXOR   = 17'b00_00_00_0_1_00_1001_000;
  localparam logic [16:0] V_SMBR   = 17'b00_00_11_0_0_00_0000_000;
  localparam logic [16:0] V_SWR    = 17'b00_00_00_0_0_00_0000_100;
  localparam logic [16:0] V_HALT   = 17'b00_00_00_0_0_00_0000_010;
  localparam logic [16:0] V_ILL    = 17'b00_00_00_0_0_00_0000_011;

  logic [16:0] vec;
  assign vec = {bus.pc_write, bus.pc_sel, bus.mar_write, bus.mar_sel, bus.mbr_write,
                bus.mbr_sel, bus.ir_write, bus.acc_write, bus.acc_sel, bus.alu_opcode,
                bus.mem_write_enable, bus.halted, bus.illegal};

  logic [15:0] pc, mar, mbr, ir, acc;
  logic [15:0] acc_init = 16'h0000;
  logic        mem_load = 1'b1;
  logic [15:0] mem [64];
  logic [15:0] img [64];
  logic [15:0] alu_y;
  int          cyc = 0;

  assign bus.ir_opcode = ir[15:12];
  assign bus.acc_zero  = (acc == 16'h0000);

  always_comb begin
    alu_y = 16'h0000;
    case (bus.alu_opcode)
      4'b0000: alu_y = acc + mbr;
      4'b0001: alu_y = acc - mbr;
      4'b1000: alu_y = acc & mbr;
      4'b1001: alu_y = acc | mbr;
      default: alu_y = 16'h0000;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset) begin
      pc  <= 16'h0000;
      mar <= 16'h0000;
      mbr <= 16'h0000;
      ir  <= 16'h0000;
      acc <= acc_init;
      if (mem_load) for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else begin
      if (bus.pc_write)  pc  <= bus.pc_sel ? {4'h0, ir[11:0]} : pc + 16'h1;
      if (bus.mar_write) mar <= bus.mar_sel ? {4'h0, ir[11:0]} : pc;
      if (bus.mbr_write) mbr <= bus.mbr_sel ? acc : mem[mar[5:0]];
      if (bus.ir_write)  ir  <= mbr;
      if (bus.acc_write)
        case (bus.acc_sel)
          2'd0:    acc <= alu_y;
          2'd1:    acc <= mbr;
          default: acc <= 16'h0000;
        endcase
      if (bus.mem_write_enable) mem[mar[5:0]] <= mbr;
    end
  end

  typedef struct {
    int          cyc;
    logic [16:0] vec;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   t0 = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vec !== 17'd0) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: cyc=%0d got=%b want=none", cyc, vec);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cyc || e.vec !== vec) begin
            bad++;
            $display("FAIL %s: cyc got=%0d want=%0d outputs got=%b want=%b",
                     e.name, cyc, e.cyc, vec, e.vec);
          end
        end
      end
    end
  endtask

  task automatic push(input int k, input logic [16:0] v, input string n);
    exp_t e;
    e.cyc  = t0 + k;
    e.vec  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic push_fetch(input int k);
    push(k, V_FADDR, "f_addr");
    push(k + 2, V_FLOAD, "f_load");
    push(k + 3, V_FIR, "f_ir");
  endtask

  task automatic push_memop(input int k, input logic [16:0] ex, input string n);
    push_fetch(k);
    push(k + 4, V_DMEM, "decode_mem");
    push(k + 6, V_OLOAD, "o_load");
    push(k + 7, ex, n);
  endtask

  task automatic push_store(input int k);
    push_fetch(k);
    push(k + 4, V_DMEM, "decode_store");
    push(k + 5, V_SMBR, "s_mbr");
    push(k + 6, V_SWR, "s_wr");
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 16'h0000;
  endtask

  task automatic do_reset();
    run      = 1'b0;
    reset    = 1'b0;
    mem_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset    = 1'b1;
    mem_load = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    t0  = cyc;
  endtask

  task automatic wait_until(input int k);
    while (cyc < t0 + k) @(negedge clk);
    #1;
  endtask

  task automatic drain(input string n);
    check(n, sb_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    clear_img();

    // reset state, run low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", vec, 17'd0);
    end

    // two LOADs back to back, run dropped during the second
    clear_img();
    img[0] = 16'h1005; img[1] = 16'h1005; img[5] = 16'h00AA;
    acc_init = 16'h0000;
    do_reset(); start();
    push_memop(1, V_EXLOAD, "exec_load");
    push_memop(9, V_EXLOAD, "exec_load2");
    wait_until(10); run = 1'b0;
    wait_until(24);
    check("load_acc", acc, 16'h00AA);
    check("load_pc", pc, 16'h0002);
    drain("load_drain");

    // STORE 7
    clear_img();
    img[0] = 16'h2007; img[7] = 16'hFFFF;
    acc_init = 16'h1234;
    do_reset(); start();
    push_store(1);
    wait_until(3); run = 1'b0;
    wait_until(14);
    check("store_mem", mem[7], 16'h1234);
    check("store_mar", mar, 16'h0007);
    drain("store_drain");

    // SKIPZ taken, then STORE
    clear_img();
    img[0] = 16'h8000; img[1] = 16'h1005; img[2] = 16'h2010; img[16] = 16'hFFFF;
    acc_init = 16'h0000;
    do_reset(); start();
    push_fetch(1);
    push(5, V_DSKIP, "decode_skipz");
    push_store(6);
    wait_until(7); run = 1'b0;
    wait_until(18);
    check("skipz_taken_pc", pc, 16'h0003);
    check("skipz_taken_mem", mem[16], 16'h0000);
    drain("skipz_taken_drain");

    // SKIPZ not taken, then STORE
    clear_img();
    img[0] = 16'h8000; img[1] = 16'h2011;
    acc_init = 16'h0005;
    do_reset(); start();
    push_fetch(1);
    push_store(6);
    wait_until(7); run = 1'b0;
    wait_until(18);
    check("skipz_fall_pc", pc, 16'h0002);
    check("skipz_fall_mem", mem[17], 16'h0005);
    drain("skipz_fall_drain");

    // ADD with run dropped during O_WAIT
    clear_img();
    img[0] = 16'h3009; img[9] = 16'h0004;
    acc_init = 16'h0003;
    do_reset(); start();
    push_memop(1, V_EXADD, "exec_add");
    wait_until(6); run = 1'b0;
    wait_until(14);
    check("add_acc", acc, 16'h0007);
    drain("add_drain");

    // ADD, SUB, AND, OR chain
    clear_img();
    img[0] = 16'h3009; img[1] = 16'h4009; img[2] = 16'h5009; img[3] = 16'h6009;
    img[9] = 16'h003C;
    acc_init = 16'h00F0;
    do_reset(); start();
    push_memop(1, V_EXADD, "exec_add");
    push_memop(9, V_EXSUB, "exec_sub");
    push_memop(17, V_EXAND, "exec_and");
    push_memop(25, V_EXOR, "exec_or");
    wait_until(26); run = 1'b0;
    wait_until(36);
    check("alu_chain_acc", acc, 16'h003C);
    check("alu_chain_pc", pc, 16'h0004);
    drain("alu_chain_drain");

    // JUMP 4, CLEAR, STORE 0x20
    clear_img();
    img[0] = 16'h7004; img[4] = 16'hA000; img[5] = 16'h2020; img[32] = 16'hFFFF;
    acc_init = 16'h0055;
    do_reset(); start();
    push_fetch(1);
    push(5, V_DJUMP, "decode_jump");
    push_fetch(6);
    push(10, V_DCLEAR, "decode_clear");
    push_store(11);
    wait_until(12); run = 1'b0;
    wait_until(22);
    check("jump_clear_mem", mem[32], 16'h0000);
    check("jump_clear_pc", pc, 16'h0006);
    drain("jump_clear_drain");

    // HALT
    clear_img();
    img[0] = 16'h9000;
    do_reset(); start();
    push_fetch(1);
    for (int k = 6; k <= 10; k++) push(k, V_HALT, "halted");
    wait_until(10);
    reset = 1'b0; run = 1'b0;
    #1;
    check("halt_reset_clear", bus.halted, 1'b0);
    drain("halt_drain");

    // illegal opcode C
    clear_img();
    img[0] = 16'hC000;
    do_reset(); start();
    push_fetch(1);
    for (int k = 6; k <= 25; k++) push(k, V_ILL, "illegal_halted");
    wait_until(25);
    reset = 1'b0; run = 1'b0;
    #1;
    check("illegal_reset_clear", bus.illegal, 1'b0);
    check("illegal_halted_clear", bus.halted, 1'b0);
    drain("illegal_drain");

    // reset pulse during S_WR drops the write
    clear_img();
    img[0] = 16'h2007; img[7] = 16'hBEEF;
    acc_init = 16'h1111;
    do_reset(); start();
    push_store(1);
    wait_until(7);
    reset = 1'b0; run = 1'b0;
    #1;
    check("swr_abort_we", bus.mem_write_enable, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("swr_abort_mem", mem[7], 16'hBEEF);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    drain("swr_abort_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
